// File: rtl/spike_counter_bank.sv
// spike_counter_bank: windowed per-channel spike edge counters with snapshot read mux.
// Define SPIKE_CNT_OVF_EN to make counters saturate with sticky ovf flags; otherwise counters wrap.
module spike_counter_bank #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 32,
    parameter int WIN_W = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset_global,
    input  logic [N_CH-1:0]  spike_in,
    input  logic             sim_tick,
    input  logic [WIN_W-1:0] window_len,
    input  logic             clear,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_count,
    output logic             snap_valid,
    output logic [WIN_W-1:0] win_pos,
    output logic [N_CH-1:0]  ovf
);
    logic [N_CH-1:0]  spike_d;
    logic [N_CH-1:0]  ev;
    logic [CNT_W-1:0] live    [N_CH];
    logic [CNT_W-1:0] snap    [N_CH];
    logic [CNT_W-1:0] live_nx [N_CH];
    logic [CNT_W-1:0] rd_mux;
    logic             cum;
    logic             boundary;
    assign ev  = spike_in & ~spike_d;
    assign cum = window_len == '0;
    // >= so a window shortened below the current position closes on the next tick
    assign boundary = !cum && sim_tick && (win_pos >= window_len - WIN_W'(1));
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
`ifdef SPIKE_CNT_OVF_EN
            live_nx[i] = (&live[i]) ? live[i] : live[i] + CNT_W'(1);
`else
            live_nx[i] = live[i] + CNT_W'(1);
`endif
        end
    end
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < N_CH; c++)
            if (rd_sel == SEL_W'(c)) rd_mux = snap[c];
    end
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            spike_d    <= '0;
            win_pos    <= '0;
            snap_valid <= 1'b0;
            rd_count   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                live[i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            spike_d    <= spike_in;
            snap_valid <= boundary && !clear;
            rd_count   <= rd_mux;
            win_pos    <= (clear || cum || boundary) ? '0 : sim_tick ? win_pos + WIN_W'(1) : win_pos;
            for (int i = 0; i < N_CH; i++) begin
                if (clear) begin
                    live[i] <= '0;
                    snap[i] <= '0;
                end else begin
                    if (boundary) live[i] <= CNT_W'(ev[i]);
                    else if (ev[i]) live[i] <= live_nx[i];
                    if (boundary || cum) snap[i] <= live[i];
                end
            end
        end
    end
`ifdef SPIKE_CNT_OVF_EN
    logic [N_CH-1:0] sat;
    always_comb begin
        for (int i = 0; i < N_CH; i++) sat[i] = &live[i];
    end
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) ovf <= '0;
        else if (clear) ovf <= '0;
        else ovf <= ovf | (ev & sat & {N_CH{!boundary}});
    end
`else
    assign ovf = '0;
`endif
endmodule
